// File: rtl/fd_pipe_reg_pkg.sv
// Shared CPU definitions for the fetch/decode boundary: reset/handler PCs,
// the legal fetch window and exception codes.
package fd_pipe_reg_pkg;
  localparam logic [31:0] PC_INIT    = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] PC_LO      = 32'h0000_3000;
  localparam logic [31:0] PC_HI      = 32'h0000_6ffc;

  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fd_pipe_reg_if.sv
// F->D boundary bundle: the fetch side drives F_* and the control inputs,
// and the pipe register drives the D_* view seen by decode.
interface fd_pipe_reg_if;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_IsBD;
  logic        Stall;
  logic        Req;
  logic        D_Eret;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_IsBD;
  logic        D_Valid;

  modport master (
    output F_PC, F_Instr, F_IsBD, Stall, Req, D_Eret,
    input  D_PC, D_Instr, D_ExcCode, D_IsBD, D_Valid
  );

  modport slave (
    input  F_PC, F_Instr, F_IsBD, Stall, Req, D_Eret,
    output D_PC, D_Instr, D_ExcCode, D_IsBD, D_Valid
  );
endinterface

// File: rtl/fd_pipe_reg_fetch_exc_check.sv
// Combinational AdEL check: misaligned word address or outside [LO, HI].
// Also used for data-side load address range checks.
module fetch_exc_check
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] LO = PC_LO,
  parameter logic [31:0] HI = PC_HI
) (
  input  logic [31:0] i_addr,
  output logic        o_fault,
  output logic [4:0]  o_exc_code
);
  logic w_misaligned;
  logic w_out_of_range;

  // Unsigned compares, so addresses near 32'hffff_fffc cannot wrap into range.
  assign w_misaligned   = (i_addr[1:0] != 2'b00);
  assign w_out_of_range = (i_addr < LO) || (i_addr > HI);
  assign o_fault        = w_misaligned || w_out_of_range;
  assign o_exc_code     = o_fault ? EXC_ADEL : EXC_NONE;
endmodule

// File: rtl/fd_pipe_reg.sv
// F->D pipeline register: fetch AdEL check, nop substitution, delay-slot flag,
// and reset > Req > Stall > D_Eret > load priority on every edge.
module fd_pipe_reg
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] P_PC_INIT    = PC_INIT,
  parameter logic [31:0] P_PC_LO      = PC_LO,
  parameter logic [31:0] P_PC_HI      = PC_HI,
  parameter logic [31:0] P_HANDLER_PC = HANDLER_PC
) (
  input logic          clk,
  input logic          reset,
  fd_pipe_reg_if.slave bus
);
  logic        w_fault;
  logic [4:0]  w_exc_code;

  logic [31:0] r_pc_p1;
  logic [31:0] r_instr_p1;
  logic [4:0]  r_exc_code_p1;
  logic        r_is_bd_p1;
  logic        r_vld_p1;

  fetch_exc_check #(
    .LO (P_PC_LO),
    .HI (P_PC_HI)
  ) u_fetch_exc_check (
    .i_addr     (bus.F_PC),
    .o_fault    (w_fault),
    .o_exc_code (w_exc_code)
  );

  // F -> D stage boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_p1       <= P_PC_INIT;
      r_instr_p1    <= NOP;
      r_exc_code_p1 <= EXC_NONE;
      r_is_bd_p1    <= 1'b0;
      r_vld_p1      <= 1'b0;
    end else if (bus.Req) begin
      // Exception entry flushes D even under a stall.
      r_pc_p1       <= P_HANDLER_PC;
      r_instr_p1    <= NOP;
      r_exc_code_p1 <= EXC_NONE;
      r_is_bd_p1    <= 1'b0;
      r_vld_p1      <= 1'b0;
    end else if (bus.Stall) begin
      r_pc_p1       <= r_pc_p1;
      r_instr_p1    <= r_instr_p1;
      r_exc_code_p1 <= r_exc_code_p1;
      r_is_bd_p1    <= r_is_bd_p1;
      r_vld_p1      <= r_vld_p1;
    end else if (bus.D_Eret) begin
      // Kill the successor of eret but keep its PC for the macro PC view.
      r_pc_p1       <= bus.F_PC;
      r_instr_p1    <= NOP;
      r_exc_code_p1 <= EXC_NONE;
      r_is_bd_p1    <= 1'b0;
      r_vld_p1      <= 1'b0;
    end else begin
      r_pc_p1       <= bus.F_PC;
      r_instr_p1    <= w_fault ? NOP : bus.F_Instr;
      r_exc_code_p1 <= w_exc_code;
      r_is_bd_p1    <= bus.F_IsBD;
      r_vld_p1      <= 1'b1;
    end
  end

  assign bus.D_PC      = r_pc_p1;
  assign bus.D_Instr   = r_instr_p1;
  assign bus.D_ExcCode = r_exc_code_p1;
  assign bus.D_IsBD    = r_is_bd_p1;
  assign bus.D_Valid   = r_vld_p1;
endmodule
